// File: rtl/dispatch_queue_if.sv
// Decode-to-unit bundle for dispatch_queue: master drives decode/ready, slave is the queue.
// Head outputs are registered-state only; unit readies never reach them combinationally.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 16
`endif
interface dispatch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int BUS_W  = 64,
  parameter int FU_NUM = 8,
  parameter int INFO_W = `DECINFO_WIDTH
);
  logic                     flush_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [INFO_W-1:0]        dec_info_bus_i;
  logic [31:0]              dec_imm_i;
  logic [31:0]              dec_pc_i;
  logic [31:0]              rs1_rdata_i;
  logic [31:0]              rs2_rdata_i;
  logic [FU_NUM-1:0]        fu_valid_o;
  logic [FU_NUM-1:0]        fu_ready_i;
  logic [INFO_W-1:0]        out_info_o;
  logic [31:0]              out_imm_o;
  logic [31:0]              out_pc_o;
  logic [31:0]              out_rs1_o;
  logic [31:0]              out_rs2_o;
  logic [31:0]              mem_addr_o;
  logic [BUS_W/8-1:0]       mem_wmask_o;
  logic [BUS_W-1:0]         mem_wdata_o;
  logic                     illegal_grp_o;
  logic                     misaligned_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output flush_i, in_valid_i, dec_info_bus_i, dec_imm_i, dec_pc_i,
           rs1_rdata_i, rs2_rdata_i, fu_ready_i,
    input  in_ready_o, fu_valid_o, out_info_o, out_imm_o, out_pc_o, out_rs1_o,
           out_rs2_o, mem_addr_o, mem_wmask_o, mem_wdata_o, illegal_grp_o,
           misaligned_o, count_o
  );

  modport slave (
    input  flush_i, in_valid_i, dec_info_bus_i, dec_imm_i, dec_pc_i,
           rs1_rdata_i, rs2_rdata_i, fu_ready_i,
    output in_ready_o, fu_valid_o, out_info_o, out_imm_o, out_pc_o, out_rs1_o,
           out_rs2_o, mem_addr_o, mem_wmask_o, mem_wdata_o, illegal_grp_o,
           misaligned_o, count_o
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order DEPTH-entry dispatch FIFO: head issues one cycle after enqueue to unit GRP, stalls decode when full.
// Decode info: [3:0]=GRP, [7:4]=LSU op. DISP_MISALIGN_EXC_EN holds a misaligned head until flush.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 16
`endif
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_W  = 64,
  parameter int FU_NUM = 8,
  parameter int INFO_W = `DECINFO_WIDTH
) (
  input logic             clk,
  input logic             rst,
  dispatch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = BUS_W / 8;
  localparam int OW = $clog2(NB);
  localparam logic [3:0] GRP_LSU = 4'd2;
  localparam logic [3:0] OP_SB   = 4'd8;
  localparam logic [3:0] OP_SH   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;

  logic [INFO_W-1:0] r_info [DEPTH];
  logic [31:0]       r_imm  [DEPTH];
  logic [31:0]       r_pc   [DEPTH];
  logic [31:0]       r_rs1  [DEPTH];
  logic [31:0]       r_rs2  [DEPTH];
  logic [31:0]       r_addr [DEPTH];
  logic [CW-1:0]     r_wptr;
  logic [CW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic [AW-1:0]     w_widx;
  logic [AW-1:0]     w_ridx;
  logic              w_empty;
  logic              w_full;
  logic [INFO_W-1:0] w_head_info;
  logic [31:0]       w_head_addr;
  logic [31:0]       w_head_rs2;
  logic [3:0]        w_grp;
  logic [3:0]        w_op;
  logic              w_legal;
  logic [FU_NUM-1:0] w_sel;
  logic              w_exc_hold;
  logic              w_issue;
  logic              w_fire;
  logic              w_illegal;
  logic              w_enq;
  logic              w_deq;
  logic [OW-1:0]     w_off;
  logic [OW-1:0]     w_off_h;
  logic [OW-1:0]     w_off_w;
  logic [NB-1:0]     w_wmask;
  logic [BUS_W-1:0]  w_wdata;

  assign w_widx      = r_wptr[AW-1:0];
  assign w_ridx      = r_rptr[AW-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
  assign w_head_info = r_info[w_ridx];
  assign w_head_addr = r_addr[w_ridx];
  assign w_head_rs2  = r_rs2[w_ridx];
  assign w_grp       = w_head_info[3:0];
  assign w_op        = w_head_info[7:4];

  assign w_legal   = (w_grp != 4'd0) && ({28'd0, w_grp} < 32'(FU_NUM));
  assign w_sel     = FU_NUM'(1) << w_grp;
  assign w_issue   = !w_empty && w_legal && !w_exc_hold;
  assign w_fire    = w_issue && |(w_sel & q.fu_ready_i);
  assign w_illegal = !w_empty && !w_legal && !w_exc_hold;
  // Flush wins over both sides: nothing written, nothing retired this cycle.
  assign w_enq     = !q.flush_i && q.in_valid_i && !w_full;
  assign w_deq     = !q.flush_i && (w_fire || w_illegal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_info[i] <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_rs1[i]  <= '0;
        r_rs2[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else if (q.flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_info[w_widx] <= q.dec_info_bus_i;
        r_imm[w_widx]  <= q.dec_imm_i;
        r_pc[w_widx]   <= q.dec_pc_i;
        r_rs1[w_widx]  <= q.rs1_rdata_i;
        r_rs2[w_widx]  <= q.rs2_rdata_i;
        r_addr[w_widx] <= q.rs1_rdata_i + q.dec_imm_i;
        r_wptr         <= r_wptr + CW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + CW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Half/word stores snap to their size-aligned lane group.
  assign w_off   = w_head_addr[OW-1:0];
  assign w_off_h = w_off & ~OW'(1);
  assign w_off_w = w_off & ~OW'(3);

  always_comb begin
    w_wmask = '0;
    w_wdata = '0;
    if (!w_empty && (w_grp == GRP_LSU)) begin
      case (w_op)
        OP_SB: begin
          w_wmask = NB'(1) << w_off;
          w_wdata = BUS_W'(w_head_rs2[7:0]) << {w_off, 3'b000};
        end
        OP_SH: begin
          w_wmask = NB'(3) << w_off_h;
          w_wdata = BUS_W'(w_head_rs2[15:0]) << {w_off_h, 3'b000};
        end
        OP_SW: begin
          w_wmask = NB'(15) << w_off_w;
          w_wdata = BUS_W'(w_head_rs2) << {w_off_w, 3'b000};
        end
        default: ;
      endcase
    end
  end

`ifdef DISP_MISALIGN_EXC_EN
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;
  state_t r_state;
  logic   w_head_misal;

  always_comb begin
    w_head_misal = 1'b0;
    if (!w_empty && (w_grp == GRP_LSU)) begin
      case (w_op)
        OP_LH, OP_LHU, OP_SH: w_head_misal = w_head_addr[0];
        OP_LW, OP_SW:         w_head_misal = |w_head_addr[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (!q.flush_i && w_head_misal) r_state <= ST_HOLD;
        ST_HOLD: if (q.flush_i) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_exc_hold     = w_head_misal || (r_state == ST_HOLD);
  assign q.misaligned_o = w_head_misal;
`else
  assign w_exc_hold     = 1'b0;
  assign q.misaligned_o = 1'b0;
`endif

  assign q.in_ready_o    = !w_full;
  assign q.fu_valid_o    = w_issue ? w_sel : '0;
  assign q.illegal_grp_o = w_illegal;
  assign q.out_info_o    = w_head_info;
  assign q.out_imm_o     = r_imm[w_ridx];
  assign q.out_pc_o      = r_pc[w_ridx];
  assign q.out_rs1_o     = r_rs1[w_ridx];
  assign q.out_rs2_o     = w_head_rs2;
  assign q.mem_addr_o    = w_head_addr;
  assign q.mem_wmask_o   = w_wmask;
  assign q.mem_wdata_o   = w_wdata;
  assign q.count_o       = r_count;
endmodule
